// File: rtl/spi_frame_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_frame_rx                                               |
// | Description : SPI slave frame deserialiser. Receives one opcode field    |
// |               followed by NUM_WORDS data words on clk_spi while cs_n is  |
// |               low, and presents each completed frame in a holding        |
// |               register with a valid/ready handshake. Reports overrun,    |
// |               aborted frames and, when SPI_RX_CRC8_EN is defined, a      |
// |               trailing CRC-8 (poly 0x07, init 0x00) mismatch.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module spi_frame_rx #(
  parameter int OPCODE_W  = 8,
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 5,
  parameter int MSB_FIRST = 1
) (
  input  logic                          clk_spi,
  input  logic                          rstb,
  input  logic                          cs_n_i,
  input  logic                          spi_mosi_i,
  output logic [OPCODE_W-1:0]           opcode_o,
  output logic [NUM_WORDS*WORD_W-1:0]   data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          busy_o,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  output logic                          crc_err_o
);

  localparam int DATA_BITS = NUM_WORDS * WORD_W;
`ifdef SPI_RX_CRC8_EN
  localparam int CRC_BITS = 8;
`else
  localparam int CRC_BITS = 0;
`endif
  localparam int FRAME_BITS = OPCODE_W + DATA_BITS + CRC_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int WB_W       = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0] C_OP_END    = CNT_W'(OPCODE_W);
  localparam logic [CNT_W-1:0] C_DATA_END  = CNT_W'(OPCODE_W + DATA_BITS);
  localparam logic [CNT_W-1:0] C_FRAME_END = CNT_W'(FRAME_BITS);
  localparam logic [WB_W-1:0]  C_WORD_LAST = WB_W'(WORD_W - 1);

`ifdef SPI_RX_CRC8_EN
  typedef enum logic [1:0] {S_IDLE, S_OPCODE, S_DATA, S_CRC} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_OPCODE, S_DATA} state_t;
`endif

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_inc;
  logic [WB_W-1:0]          wbit_q;
  logic [OPCODE_W-1:0]      op_sh_q, op_sh_d;
  logic [WORD_W-1:0]        word_sh_q, word_sh_d;
  logic [DATA_BITS-1:0]     data_buf_q, buf_d, load_data;
  logic [OPCODE_W-1:0]      opcode_q;
  logic [DATA_BITS-1:0]     data_q;
  logic                     valid_q;
  logic                     frame_err_q;
  logic                     overrun_q;
  logic                     word_done, frame_last, is_op, is_data;
  logic                     frame_end, good_end, accept, hold_free;
  logic                     crc_ok;

`ifdef SPI_RX_CRC8_EN
  logic [7:0] crc_q, crc_d, crc_rx_q, crc_rx_d;
  logic       crc_err_q;
  logic       is_crc;

  // Running CRC over opcode/data bits and shift-in of the received CRC byte
  always_comb begin
    crc_d    = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ spi_mosi_i) ? 8'h07 : 8'h00);
    crc_rx_d = {crc_rx_q[6:0], spi_mosi_i};
    crc_ok   = (crc_rx_d == crc_q);
    is_crc   = (state_q == S_CRC);
  end

  // The data buffer is already complete by the time the CRC byte arrives
  assign load_data = data_buf_q;
  assign crc_err_o = crc_err_q;
`else
  assign crc_ok    = 1'b1;
  assign load_data = buf_d;
  assign crc_err_o = 1'b0;
`endif

  // Next-value decode: field shifts, word assembly, bit classification and next state
  always_comb begin
    cnt_inc = cnt_q + CNT_W'(1);
    if (MSB_FIRST != 0) begin
      op_sh_d      = op_sh_q << 1;
      op_sh_d[0]   = spi_mosi_i;
      word_sh_d    = word_sh_q << 1;
      word_sh_d[0] = spi_mosi_i;
    end else begin
      op_sh_d              = op_sh_q >> 1;
      op_sh_d[OPCODE_W-1]  = spi_mosi_i;
      word_sh_d            = word_sh_q >> 1;
      word_sh_d[WORD_W-1]  = spi_mosi_i;
    end
    // Completed words enter at the top so the first word ends up at the bottom
    buf_d = data_buf_q >> WORD_W;
    buf_d[DATA_BITS-1 -: WORD_W] = word_sh_d;

    word_done  = (wbit_q == C_WORD_LAST);
    frame_last = (cnt_inc == C_FRAME_END);
    is_op      = (state_q == S_IDLE) || (state_q == S_OPCODE);
    is_data    = (state_q == S_DATA);

    if (frame_last) begin
      state_d = S_IDLE;
    end else if (cnt_inc < C_OP_END) begin
      state_d = S_OPCODE;
    end else if (cnt_inc < C_DATA_END) begin
      state_d = S_DATA;
    end else begin
`ifdef SPI_RX_CRC8_EN
      state_d = S_CRC;
`else
      state_d = S_DATA;
`endif
    end

    frame_end = !cs_n_i && frame_last;
    good_end  = frame_end && crc_ok;
    accept    = valid_q && ready_i;
    hold_free = !valid_q || accept;
  end

  // Frame reception FSM, holding register handshake and event pulses
  always_ff @(posedge clk_spi or negedge rstb) begin
    if (!rstb) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wbit_q      <= '0;
      op_sh_q     <= '0;
      word_sh_q   <= '0;
      data_buf_q  <= '0;
      opcode_q    <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SPI_RX_CRC8_EN
      crc_q       <= '0;
      crc_rx_q    <= '0;
      crc_err_q   <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      if (cs_n_i) begin
        // Deselect mid-frame throws the partial frame away
        if (cnt_q != '0) begin
          frame_err_q <= 1'b1;
          cnt_q       <= '0;
          wbit_q      <= '0;
          state_q     <= S_IDLE;
`ifdef SPI_RX_CRC8_EN
          crc_q       <= '0;
`endif
        end
      end else begin
        cnt_q   <= frame_last ? '0 : cnt_inc;
        state_q <= state_d;
        if (is_op) begin
          op_sh_q <= op_sh_d;
        end
        if (is_data) begin
          word_sh_q <= word_sh_d;
          if (word_done) begin
            data_buf_q <= buf_d;
            wbit_q     <= '0;
          end else begin
            wbit_q <= wbit_q + WB_W'(1);
          end
        end
`ifdef SPI_RX_CRC8_EN
        if (frame_last) begin
          crc_q <= '0;
        end else if (is_op || is_data) begin
          crc_q <= crc_d;
        end
        if (is_crc) begin
          crc_rx_q <= crc_rx_d;
        end
`endif
      end

      // A frame ending on an accept edge loads straight into the freed slot
      if (good_end && hold_free) begin
        opcode_q <= op_sh_q;
        data_q   <= load_data;
        valid_q  <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
      overrun_q <= good_end && !hold_free;
`ifdef SPI_RX_CRC8_EN
      crc_err_q <= frame_end && !crc_ok;
`endif
    end
  end

  assign opcode_o    = opcode_q;
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign busy_o      = (cnt_q != '0);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_spi_frame_rx                                            |
// | Description : Directed self-checking bench for spi_frame_rx (default     |
// |               MSB-first instance plus a small LSB-first instance).       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_spi_frame_rx;

`ifdef SPI_RX_CRC8_EN
  localparam int CRCB = 8;
`else
  localparam int CRCB = 0;
`endif
  localparam int FB_A = 8 + 5 * 16 + CRCB;
  localparam int FB_B = 4 + 2 * 8 + CRCB;

  logic        clk_spi = 1'b0;
  logic        rstb    = 1'b0;

  logic        cs_a = 1'b1, mosi_a = 1'b0, ready_a = 1'b0;
  logic [7:0]  opcode_a;
  logic [79:0] data_a;
  logic        valid_a, busy_a, ferr_a, ovr_a, cerr_a;

  logic        cs_b = 1'b1, mosi_b = 1'b0, ready_b = 1'b0;
  logic [3:0]  opcode_b;
  logic [15:0] data_b;
  logic        valid_b, busy_b, ferr_b, ovr_b, cerr_b;

  int checks   = 0;
  int failures = 0;
  bit fq[$];

  always #5 clk_spi = ~clk_spi;

  spi_frame_rx u_dut_a (
    .clk_spi     (clk_spi),
    .rstb        (rstb),
    .cs_n_i      (cs_a),
    .spi_mosi_i  (mosi_a),
    .opcode_o    (opcode_a),
    .data_o      (data_a),
    .valid_o     (valid_a),
    .ready_i     (ready_a),
    .busy_o      (busy_a),
    .frame_err_o (ferr_a),
    .overrun_o   (ovr_a),
    .crc_err_o   (cerr_a)
  );

  spi_frame_rx #(.OPCODE_W(4), .WORD_W(8), .NUM_WORDS(2), .MSB_FIRST(0)) u_dut_b (
    .clk_spi     (clk_spi),
    .rstb        (rstb),
    .cs_n_i      (cs_b),
    .spi_mosi_i  (mosi_b),
    .opcode_o    (opcode_b),
    .data_o      (data_b),
    .valid_o     (valid_b),
    .ready_i     (ready_b),
    .busy_o      (busy_b),
    .frame_err_o (ferr_b),
    .overrun_o   (ovr_b),
    .crc_err_o   (cerr_b)
  );

  task automatic step();
    @(posedge clk_spi);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_field(input logic [31:0] v, input int w, input bit msb);
    for (int i = 0; i < w; i++) fq.push_back(msb ? v[w-1-i] : v[i]);
  endtask

  // Appends CRC-8 (poly 0x07, init 0) of everything queued so far, MSB first
  task automatic push_crc();
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (fq[i]) begin
      fb = c[7] ^ fq[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    for (int i = 7; i >= 0; i--) fq.push_back(c[i]);
  endtask

  task automatic build_a(input logic [7:0] op, input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3, input logic [15:0] w4);
    fq.delete();
    push_field({24'h0, op}, 8, 1'b1);
    push_field({16'h0, w0}, 16, 1'b1);
    push_field({16'h0, w1}, 16, 1'b1);
    push_field({16'h0, w2}, 16, 1'b1);
    push_field({16'h0, w3}, 16, 1'b1);
    push_field({16'h0, w4}, 16, 1'b1);
    if (CRCB != 0) push_crc();
  endtask

  task automatic send_a(input int from, input int to);
    for (int i = from; i < to; i++) begin
      cs_a   = 1'b0;
      mosi_a = fq[i];
      step();
    end
  endtask

  task automatic send_b(input int from, input int to);
    for (int i = from; i < to; i++) begin
      cs_b   = 1'b0;
      mosi_b = fq[i];
      step();
    end
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_valid", valid_a, 0);
    chk("rst_opcode", opcode_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_pulses", {ferr_a, ovr_a, cerr_a}, 0);
    rstb = 1'b1;
    step();

    // Test 1: default frame, valid right after the last bit
    build_a(8'hA5, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F);
    send_a(0, FB_A - 1);
    chk("t1_valid_early", valid_a, 0);
    chk("t1_busy", busy_a, 1);
    send_a(FB_A - 1, FB_A);
    chk("t1_valid", valid_a, 1);
    chk("t1_opcode", opcode_a, 8'hA5);
    chk("t1_w0", data_a[15:0], 16'h1234);
    chk("t1_w2", data_a[47:32], 16'h9ABC);
    chk("t1_w4", data_a[79:64], 16'h0F0F);
    chk("t1_busy_end", busy_a, 0);

    // Test 2: back-to-back second frame with ready=0 overruns
    build_a(8'h77, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE);
    send_a(0, FB_A - 1);
    chk("t2_no_ovr_early", ovr_a, 0);
    send_a(FB_A - 1, FB_A);
    chk("t2_ovr", ovr_a, 1);
    chk("t2_held_op", opcode_a, 8'hA5);
    chk("t2_held_w0", data_a[15:0], 16'h1234);
    chk("t2_valid", valid_a, 1);
    cs_a    = 1'b1;
    ready_a = 1'b1;
    step();
    chk("t2_ovr_single", ovr_a, 0);
    chk("t2_valid_fall", valid_a, 0);
    ready_a = 1'b0;
    build_a(8'h5A, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h8005);
    send_a(0, FB_A);
    chk("t2_next_valid", valid_a, 1);
    chk("t2_next_op", opcode_a, 8'h5A);
    chk("t2_next_w4", data_a[79:64], 16'h8005);
    // New frame ends on the same edge the held one is accepted
    build_a(8'hC3, 16'hFFFF, 16'h0000, 16'h1111, 16'h2222, 16'h3333);
    send_a(0, FB_A - 1);
    ready_a = 1'b1;
    send_a(FB_A - 1, FB_A);
    chk("t2_swap_valid", valid_a, 1);
    chk("t2_swap_op", opcode_a, 8'hC3);
    chk("t2_swap_ovr", ovr_a, 0);
    cs_a = 1'b1;
    step();
    chk("t2_accept", valid_a, 0);
    ready_a = 1'b0;

    // Test 3: abort after 40 bits, then a good frame
    build_a(8'h99, 16'h4321, 16'h8765, 16'hCBA9, 16'h0FED, 16'h1357);
    send_a(0, 40);
    chk("t3_busy_mid", busy_a, 1);
    cs_a = 1'b1;
    step();
    chk("t3_ferr", ferr_a, 1);
    chk("t3_busy", busy_a, 0);
    step();
    chk("t3_ferr_single", ferr_a, 0);
    chk("t3_no_valid", valid_a, 0);
    build_a(8'h3C, 16'h2468, 16'h1357, 16'hFACE, 16'hBEEF, 16'hCAFE);
    send_a(0, FB_A);
    chk("t3_valid", valid_a, 1);
    chk("t3_opcode", opcode_a, 8'h3C);
    chk("t3_w1", data_a[31:16], 16'h1357);
    chk("t3_w3", data_a[63:48], 16'hBEEF);
    chk("t3_ferr_none", ferr_a, 0);
    cs_a = 1'b1;

    // Test 4: LSB-first instance, opcode wire bits 1,0,0,0
    fq.delete();
    push_field(32'h1, 4, 1'b0);
    push_field(32'h3C, 8, 1'b0);
    push_field(32'h81, 8, 1'b0);
    if (CRCB != 0) push_crc();
    send_b(0, FB_B);
    chk("t4_valid", valid_b, 1);
    chk("t4_opcode", opcode_b, 4'h1);
    chk("t4_data", data_b, 16'h813C);
    cs_b = 1'b1;

    // Test 5: asynchronous reset mid-frame while a frame is held
    build_a(8'h12, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    send_a(0, 20);
    rstb = 1'b0;
    #2;
    chk("t5_valid", valid_a, 0);
    chk("t5_opcode", opcode_a, 0);
    chk("t5_data", data_a, 0);
    chk("t5_busy", busy_a, 0);
    chk("t5_valid_b", valid_b, 0);
    cs_a = 1'b1;
    step();
    rstb = 1'b1;
    step();
    build_a(8'h96, 16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005);
    send_a(0, FB_A);
    chk("t5_fresh_valid", valid_a, 1);
    chk("t5_fresh_op", opcode_a, 8'h96);
    chk("t5_fresh_w2", data_a[47:32], 16'h3003);
    cs_a    = 1'b1;
    ready_a = 1'b1;
    step();
    ready_a = 1'b0;
    chk("t5_accept", valid_a, 0);

`ifdef SPI_RX_CRC8_EN
    // Test 6: a flipped data bit causes a CRC mismatch
    build_a(8'h42, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);
    fq[20] = ~fq[20];
    send_a(0, FB_A);
    chk("t6_crc_err", cerr_a, 1);
    chk("t6_no_valid", valid_a, 0);
    chk("t6_no_ovr", ovr_a, 0);
    cs_a = 1'b1;
    step();
    chk("t6_crc_single", cerr_a, 0);
`else
    chk("t6_crc_tied", cerr_a, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
